// File: rtl/cross_bar_drr_arbiter_mx1.sv
// M-to-1 AXI-Stream packet arbiter using deficit round robin; whole packets only,
// granted channel index forwarded on m_axis_tid.
module cross_bar_drr_arbiter_mx1 #(
  parameter int unsigned MSEL_WIDTH = 2,
  parameter int unsigned CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DC_WIDTH   = 16,
  parameter int unsigned QUANTUM    = 8
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [CHANNEL_NO*DC_WIDTH-1:0] s_axis_plen,
  input  logic [CHANNEL_NO*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNEL_NO-1:0]          s_axis_tvalid,
  input  logic [CHANNEL_NO-1:0]          s_axis_tlast,
  output logic [CHANNEL_NO-1:0]          s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [MSEL_WIDTH-1:0]          m_axis_tid,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic                           len_err
);

  localparam logic [DC_WIDTH-1:0]   DC_MAX   = '1;
  localparam logic [MSEL_WIDTH-1:0] PTR_LAST = MSEL_WIDTH'(CHANNEL_NO - 1);

  typedef enum logic [1:0] {VISIT, CHECK, ACTIVE} state_t;

  state_t                  state, state_nx;
  logic [MSEL_WIDTH-1:0]   ptr, ptr_nx, ptr_inc;
  logic [DC_WIDTH-1:0]     dc    [CHANNEL_NO];
  logic [DC_WIDTH-1:0]     dc_nx [CHANNEL_NO];
  logic [DC_WIDTH-1:0]     rem, rem_nx;

  logic [DC_WIDTH-1:0]     plen_a [CHANNEL_NO];
  logic [DATA_WIDTH-1:0]   data_a [CHANNEL_NO];

  logic [DC_WIDTH-1:0]     cur_dc, cur_plen, eff_len, dc_topped;
  logic [DC_WIDTH:0]       dc_sum;
  logic                    cur_valid, cur_last;

  // Per-channel views of the flattened input buses
  for (genvar g = 0; g < CHANNEL_NO; g++) begin : g_view
    assign plen_a[g] = s_axis_plen[g*DC_WIDTH +: DC_WIDTH];
    assign data_a[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cur_dc    = dc[ptr];
  assign cur_plen  = plen_a[ptr];
  assign cur_valid = s_axis_tvalid[ptr];
  assign cur_last  = s_axis_tlast[ptr];
  assign eff_len   = (cur_plen == '0) ? DC_WIDTH'(1) : cur_plen;
  assign ptr_inc   = (ptr == PTR_LAST) ? '0 : ptr + MSEL_WIDTH'(1);

  // Quantum top-up saturates at all-ones so long packets eventually get granted
  assign dc_sum    = {1'b0, cur_dc} + (DC_WIDTH+1)'(QUANTUM);
  assign dc_topped = dc_sum[DC_WIDTH] ? DC_MAX : dc_sum[DC_WIDTH-1:0];

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= VISIT;
      ptr   <= '0;
      rem   <= '0;
      for (int i = 0; i < int'(CHANNEL_NO); i++) dc[i] <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      rem   <= rem_nx;
      for (int i = 0; i < int'(CHANNEL_NO); i++) dc[i] <= dc_nx[i];
    end
  end

  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    rem_nx        = rem;
    dc_nx         = dc;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tid    = '0;
    s_axis_tready = '0;
    len_err       = 1'b0;

    unique case (state)
      VISIT: begin
        if (!cur_valid) begin
          dc_nx[ptr] = '0;
          ptr_nx     = ptr_inc;
        end else begin
          dc_nx[ptr] = dc_topped;
          state_nx   = CHECK;
        end
      end

      CHECK: begin
        if (!cur_valid) begin
          dc_nx[ptr] = '0;
          ptr_nx     = ptr_inc;
          state_nx   = VISIT;
        end else if (eff_len <= cur_dc || cur_dc == DC_MAX) begin
          rem_nx   = eff_len;
          state_nx = ACTIVE;
        end else begin
          ptr_nx   = ptr_inc;
          state_nx = VISIT;
        end
      end

      ACTIVE: begin
        m_axis_tvalid      = cur_valid;
        m_axis_tdata       = data_a[ptr];
        m_axis_tlast       = cur_last;
        m_axis_tid         = ptr;
        s_axis_tready[ptr] = m_axis_tready;
        // Accepted beat: charge the deficit, track declared length, re-check after tlast
        if (cur_valid && m_axis_tready) begin
          if (cur_dc != '0) dc_nx[ptr] = cur_dc - DC_WIDTH'(1);
          if (rem == '0) len_err = 1'b1;
          else           rem_nx  = rem - DC_WIDTH'(1);
          if (cur_last) state_nx = CHECK;
        end
      end

      default: state_nx = VISIT;
    endcase
  end

endmodule

// File: tb/tb_cross_bar_drr_arbiter_mx1.sv
// Directed bench for the DRR arbiter: instance A (Q=8, 16-bit deficits),
// instance B (Q=4, 4-bit deficits) for skip, overrun and saturation cases.
module tb_cross_bar_drr_arbiter_mx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A
  logic         a_rst;
  logic [63:0]  a_plen;
  logic [127:0] a_tdata;
  logic [3:0]   a_tvalid, a_tlast, a_tready;
  logic [31:0]  a_m_tdata;
  logic [1:0]   a_m_tid;
  logic         a_m_tvalid, a_m_tlast, a_m_tready, a_len_err;

  // Instance B
  logic         b_rst;
  logic [15:0]  b_plen;
  logic [127:0] b_tdata;
  logic [3:0]   b_tvalid, b_tlast, b_tready;
  logic [31:0]  b_m_tdata;
  logic [1:0]   b_m_tid;
  logic         b_m_tvalid, b_m_tlast, b_m_tready, b_len_err;

  logic [3:0]   prev;
  logic [3:0]   seen[$];

  cross_bar_drr_arbiter_mx1 #(.MSEL_WIDTH(2), .CHANNEL_NO(4), .DATA_WIDTH(32),
                              .DC_WIDTH(16), .QUANTUM(8)) dut_a (
    .aclk(clk), .areset(a_rst), .s_axis_plen(a_plen), .s_axis_tdata(a_tdata),
    .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast), .s_axis_tready(a_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tid(a_m_tid), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tlast(a_m_tlast), .m_axis_tready(a_m_tready), .len_err(a_len_err));

  cross_bar_drr_arbiter_mx1 #(.MSEL_WIDTH(2), .CHANNEL_NO(4), .DATA_WIDTH(32),
                              .DC_WIDTH(4), .QUANTUM(4)) dut_b (
    .aclk(clk), .areset(b_rst), .s_axis_plen(b_plen), .s_axis_tdata(b_tdata),
    .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast), .s_axis_tready(b_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tid(b_m_tid), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tlast(b_m_tlast), .m_axis_tready(b_m_tready), .len_err(b_len_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat on instance A, check the pass-through, then let it be accepted
  task automatic beat_a(input int ch, input logic [31:0] d, input logic last, input logic err);
    a_tdata[ch*32 +: 32] = d;
    a_tlast[ch] = last;
    #1;
    chk("a_beat_tvalid", 32'(a_m_tvalid), 32'd1);
    chk("a_beat_tid", 32'(a_m_tid), 32'(ch));
    chk("a_beat_tdata", a_m_tdata, d);
    chk("a_beat_tlast", 32'(a_m_tlast), 32'(last));
    chk("a_beat_len_err", 32'(a_len_err), 32'(err));
    chk("a_beat_sready", 32'(a_tready), 32'(1 << ch));
    step();
  endtask

  task automatic beat_b(input int ch, input logic [31:0] d, input logic last, input logic err);
    b_tdata[ch*32 +: 32] = d;
    b_tlast[ch] = last;
    #1;
    chk("b_beat_tvalid", 32'(b_m_tvalid), 32'd1);
    chk("b_beat_tid", 32'(b_m_tid), 32'(ch));
    chk("b_beat_tdata", b_m_tdata, d);
    chk("b_beat_tlast", 32'(b_m_tlast), 32'(last));
    chk("b_beat_len_err", 32'(b_len_err), 32'(err));
    chk("b_beat_sready", 32'(b_tready), 32'(1 << ch));
    step();
  endtask

  task automatic wait_a(input int ch);
    int n = 0;
    #1;
    while (!a_m_tvalid && n < 40) begin
      step();
      n++;
    end
    chk("a_grant_tvalid", 32'(a_m_tvalid), 32'd1);
    chk("a_grant_tid", 32'(a_m_tid), 32'(ch));
  endtask

  task automatic wait_b(input int ch);
    int n = 0;
    #1;
    while (!b_m_tvalid && n < 40) begin
      step();
      n++;
    end
    chk("b_grant_tvalid", 32'(b_m_tvalid), 32'd1);
    chk("b_grant_tid", 32'(b_m_tid), 32'(ch));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_plen = '0; a_tdata = '0; a_tvalid = '0; a_tlast = '0; a_m_tready = 1'b1;
    b_rst = 1'b1; b_plen = '0; b_tdata = '0; b_tvalid = '0; b_tlast = '0; b_m_tready = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_tvalid", 32'(a_m_tvalid), 32'd0);
    chk("rst_tlast", 32'(a_m_tlast), 32'd0);
    chk("rst_tid", 32'(a_m_tid), 32'd0);
    chk("rst_sready", 32'(a_tready), 32'd0);
    chk("rst_len_err", 32'(a_len_err), 32'd0);
    chk("rst_dc0", 32'(dut_a.dc[0]), 32'd0);

    // 1: ch0 single 4-beat packet, tvalid two cycles after release
    a_tvalid[0] = 1'b1; a_plen[15:0] = 16'd4; a_tdata[31:0] = 32'hA0; a_rst = 1'b0;
    step();
    chk("t1_lat1_tvalid", 32'(a_m_tvalid), 32'd0);
    step();
    chk("t1_lat2_tvalid", 32'(a_m_tvalid), 32'd1);
    chk("t1_dc0_grant", 32'(dut_a.dc[0]), 32'd8);
    for (int b = 0; b < 4; b++) beat_a(0, 32'hA0 + 32'(b), b == 3, 1'b0);
    chk("t1_dc0_after", 32'(dut_a.dc[0]), 32'd4);
    a_tvalid[0] = 1'b0; a_tlast[0] = 1'b0;
    #1;
    chk("t1_check_tvalid", 32'(a_m_tvalid), 32'd0);
    step();
    chk("t1_dc0_idle", 32'(dut_a.dc[0]), 32'd0);

    // 3: ch2 packet with tready 1,0,0,1
    a_tvalid[2] = 1'b1; a_plen[47:32] = 16'd3;
    wait_a(2);
    chk("t3_dc2_grant", 32'(dut_a.dc[2]), 32'd8);
    beat_a(2, 32'hC0, 1'b0, 1'b0);
    a_tdata[95:64] = 32'hC1; a_m_tready = 1'b0;
    #1;
    chk("t3_stall_sready", 32'(a_tready), 32'd0);
    for (int s = 0; s < 2; s++) begin
      step();
      chk("t3_stall_tvalid", 32'(a_m_tvalid), 32'd1);
      chk("t3_stall_tdata", a_m_tdata, 32'hC1);
      chk("t3_stall_tlast", 32'(a_m_tlast), 32'd0);
      chk("t3_stall_dc2", 32'(dut_a.dc[2]), 32'd7);
    end
    a_m_tready = 1'b1;
    beat_a(2, 32'hC1, 1'b0, 1'b0);
    beat_a(2, 32'hC2, 1'b1, 1'b0);
    chk("t3_dc2_after", 32'(dut_a.dc[2]), 32'd5);
    a_tvalid[2] = 1'b0; a_tlast[2] = 1'b0;
    step();
    chk("t3_dc2_idle", 32'(dut_a.dc[2]), 32'd0);

    // plen=0 counts as one word: second beat overruns
    a_tvalid[2] = 1'b1; a_plen[47:32] = 16'd0;
    wait_a(2);
    beat_a(2, 32'hE0, 1'b0, 1'b0);
    beat_a(2, 32'hE1, 1'b1, 1'b1);
    chk("z_dc2_after", 32'(dut_a.dc[2]), 32'd6);
    a_tvalid[2] = 1'b0; a_tlast[2] = 1'b0;
    step();

    // 6: reset in the middle of a ch0 packet
    a_tvalid[0] = 1'b1; a_plen[15:0] = 16'd8;
    a_tvalid[1] = 1'b1; a_plen[31:16] = 16'd2;
    wait_a(0);
    beat_a(0, 32'hF0, 1'b0, 1'b0);
    beat_a(0, 32'hF1, 1'b0, 1'b0);
    a_rst = 1'b1;
    step();
    chk("t6_tvalid", 32'(a_m_tvalid), 32'd0);
    chk("t6_tlast", 32'(a_m_tlast), 32'd0);
    chk("t6_tid", 32'(a_m_tid), 32'd0);
    chk("t6_sready", 32'(a_tready), 32'd0);
    chk("t6_len_err", 32'(a_len_err), 32'd0);
    for (int i = 0; i < 4; i++) chk("t6_dc", 32'(dut_a.dc[i]), 32'd0);
    a_rst = 1'b0;
    step();
    chk("t6_lat1_tvalid", 32'(a_m_tvalid), 32'd0);
    chk("t6_dc0_visit", 32'(dut_a.dc[0]), 32'd8);
    step();
    chk("t6_lat2_tvalid", 32'(a_m_tvalid), 32'd1);
    chk("t6_restart_tid", 32'(a_m_tid), 32'd0);

    // 2: ch0 plen=6 skipped in round 1, ch1 sends two plen=2 packets
    b_tvalid = 4'b0011; b_plen[3:0] = 4'd6; b_plen[7:4] = 4'd2; b_rst = 1'b0;
    step();
    step();
    chk("t2_dc0_skip", 32'(dut_b.dc[0]), 32'd4);
    chk("t2_skip_tvalid", 32'(b_m_tvalid), 32'd0);
    wait_b(1);
    chk("t2_dc1_grant", 32'(dut_b.dc[1]), 32'd4);
    beat_b(1, 32'hB0, 1'b0, 1'b0);
    beat_b(1, 32'hB1, 1'b1, 1'b0);
    chk("t2_dc1_mid", 32'(dut_b.dc[1]), 32'd2);
    b_tlast[1] = 1'b0;
    wait_b(1);
    beat_b(1, 32'hB2, 1'b0, 1'b0);
    beat_b(1, 32'hB3, 1'b1, 1'b0);
    chk("t2_dc1_after", 32'(dut_b.dc[1]), 32'd0);
    b_tvalid[1] = 1'b0; b_tlast[1] = 1'b0;
    wait_b(0);
    chk("t2_dc0_round2", 32'(dut_b.dc[0]), 32'd8);
    for (int b = 0; b < 6; b++) beat_b(0, 32'h110 + 32'(b), b == 5, 1'b0);
    chk("t2_dc0_after", 32'(dut_b.dc[0]), 32'd2);
    b_tvalid[0] = 1'b0; b_tlast[0] = 1'b0;
    step();
    chk("t2_dc0_idle", 32'(dut_b.dc[0]), 32'd0);

    // 4: ch1 plen=3 sends 5 beats
    b_tvalid[1] = 1'b1; b_plen[7:4] = 4'd3;
    wait_b(1);
    chk("t4_dc1_grant", 32'(dut_b.dc[1]), 32'd4);
    for (int b = 0; b < 5; b++) beat_b(1, 32'hD0 + 32'(b), b == 4, b >= 3);
    chk("t4_dc1_sat0", 32'(dut_b.dc[1]), 32'd0);
    chk("t4_done_tvalid", 32'(b_m_tvalid), 32'd0);
    b_tvalid[1] = 1'b0; b_tlast[1] = 1'b0;
    step();

    // 5: 4-bit deficit grows to saturation; 20 needs 5 bits, so the largest plen (15) is declared
    b_tvalid[3] = 1'b1; b_plen[15:12] = 4'd15;
    prev = dut_b.dc[3];
    for (int n = 0; n < 100 && !b_m_tvalid; n++) begin
      step();
      if (dut_b.dc[3] != prev) begin
        seen.push_back(dut_b.dc[3]);
        prev = dut_b.dc[3];
      end
    end
    chk("t5_grant_tvalid", 32'(b_m_tvalid), 32'd1);
    chk("t5_grant_tid", 32'(b_m_tid), 32'd3);
    chk("t5_dc_steps", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("t5_dc_v1", 32'(seen[0]), 32'd4);
      chk("t5_dc_v2", 32'(seen[1]), 32'd8);
      chk("t5_dc_v3", 32'(seen[2]), 32'd12);
      chk("t5_dc_v4", 32'(seen[3]), 32'd15);
    end
    for (int b = 0; b < 20; b++) beat_b(3, 32'h500 + 32'(b), b == 19, b >= 15);
    chk("t5_dc3_after", 32'(dut_b.dc[3]), 32'd0);
    chk("t5_done_tvalid", 32'(b_m_tvalid), 32'd0);
    b_tvalid[3] = 1'b0; b_tlast[3] = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
